leiwand_rv32_uart_tx: RTL and testbench

Memory-mapped UART transmitter that sits downstream of the leiwand_rv32 core on its valid/ready memory bus, alongside simple_mem, and answers only its own address window. Writes from the core push bytes into a small FIFO; an 8N1 serializer drains the FIFO onto a single TX line at a programmable bit rate. Gives firmware and the SoC testbench a console/debug output path without polling a full UART.

---
 rtl/leiwand_rv32_uart_tx_if.sv | 13 +
 rtl/leiwand_rv32_uart_tx.sv | 207 ++++++++++++++++++++
 tb/tb_leiwand_rv32_uart_tx.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/leiwand_rv32_uart_tx_if.sv
// Valid/ready memory bus between the leiwand_rv32 core and its slaves.
// The core drives the request (master); a slave acknowledges with ready and rdata.
interface leiwand_rv32_uart_tx_if;
   logic        valid;
   logic        ready;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output valid, wen, addr, wdata, input ready, rdata);
   modport slave  (input valid, wen, addr, wdata, output ready, rdata);
endinterface

// File: rtl/leiwand_rv32_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus writes fill a byte FIFO that the serializer drains.
// Bus ack one cycle after acceptance, never back-to-back; pushes to a full FIFO are dropped and flag overflow.
module leiwand_rv32_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   leiwand_rv32_uart_tx_if.slave   bus,
   output logic                    tx
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // bus side
   logic          rdy_q, rdy_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   div_q, div_d;
   logic          hit, acc, is_rd, push_req, push, stat_rd;
   logic [1:0]    sel;
   logic [31:0]   status, rd_mux;
   logic [7:0]    lvl8;

   // fifo
   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [LW-1:0] lvl_q, lvl_d;
   logic          full, empty, pop;
   logic [7:0]    head;

   // serializer
   state_t        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   divl_q, divl_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shf_q, shf_d;
   logic          bit_end, busy;

   logic          unused_ok;
   assign unused_ok = ^{bus.wdata[31:16], bus.addr[1:0], bus.wen[3:2]};

   assign sel      = bus.addr[3:2];
   assign hit      = bus.valid && (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign acc      = hit && !rdy_q;
   assign is_rd    = (bus.wen == 4'b0000);
   assign full     = (lvl_q == DEPTH_L);
   assign empty    = (lvl_q == '0);
   assign head     = fifo_q[rptr_q];
   assign lvl8     = 8'(lvl_q);
   assign push_req = acc && !is_rd && (sel == 2'd0) && bus.wen[0];
   assign push     = push_req && !full;
   assign stat_rd  = acc && is_rd && (sel == 2'd1);

   assign status   = {16'b0, lvl8, 4'b0, ovf_q, empty, full, busy};

   always_comb begin
      rd_mux = 32'b0;
      case (sel)
         2'd1:    rd_mux = status;
         2'd2:    rd_mux = {16'b0, div_q};
         default: rd_mux = 32'b0;
      endcase
   end

   always_comb begin
      rdy_d   = acc;
      rdata_d = (acc && is_rd) ? rd_mux : 32'b0;
      // a drop on the same edge as a STATUS read must not be lost
      ovf_d   = (push_req && full) ? 1'b1 : (stat_rd ? 1'b0 : ovf_q);
      div_d   = div_q;
      if (acc && (sel == 2'd2)) begin
         if (bus.wen[0]) div_d[7:0]  = bus.wdata[7:0];
         if (bus.wen[1]) div_d[15:8] = bus.wdata[15:8];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdy_q   <= 1'b0;
         rdata_q <= 32'b0;
         ovf_q   <= 1'b0;
         div_q   <= 16'(CLK_DIV - 1);
      end else begin
         rdy_q   <= rdy_d;
         rdata_q <= rdata_d;
         ovf_q   <= ovf_d;
         div_q   <= div_d;
      end
   end

   assign bus.ready = rdy_q;
   assign bus.rdata = rdata_q;

   always_comb begin
      lvl_d = lvl_q;
      case ({push, pop})
         2'b10:   lvl_d = lvl_q + LW'(1);
         2'b01:   lvl_d = lvl_q - LW'(1);
         default: lvl_d = lvl_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         lvl_q  <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         lvl_q <= lvl_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q] <= bus.wdata[7:0];
   end

   assign bit_end = (cnt_q == divl_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'b0;
         divl_q  <= 16'b0;
         bit_q   <= 3'b0;
         shf_q   <= 8'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         divl_q  <= divl_d;
         bit_q   <= bit_d;
         shf_q   <= shf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      divl_d  = divl_q;
      bit_d   = bit_q;
      shf_d   = shf_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               shf_d   = head;
               divl_d  = div_q;
               cnt_d   = 16'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               cnt_d   = 16'b0;
               bit_d   = 3'b0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d = 16'b0;
               shf_d = {1'b0, shf_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               cnt_d = 16'b0;
               // chain straight into the next start bit when more data waits
               if (pop) begin
                  shf_d   = head;
                  divl_d  = div_q;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx   = 1'b1;
      busy = (state_q != S_IDLE);
      pop  = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
      case (state_q)
         S_START: tx = 1'b0;
         S_DATA:  tx = shf_q[0];
         default: tx = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_leiwand_rv32_uart_tx.sv
// Bench for leiwand_rv32_uart_tx: bus writes queue expected frames, a UART monitor decodes tx and compares.
module tb_leiwand_rv32_uart_tx;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tx;

   leiwand_rv32_uart_tx_if bus();

   leiwand_rv32_uart_tx #(
      .BASE_ADDR (BASE),
      .CLK_DIV   (16),
      .FIFO_DEPTH(8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus),
      .tx   (tx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit mon_en = 1'b0;
   bit mon_busy = 1'b0;
   logic [23:0] sb [$];   // {div, byte} of each frame expected on tx
   int starts [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_xfer(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d,
                           input int tmo, output bit acked, output logic [31:0] rdv, output int lat);
      @(negedge clk);
      bus.valid = 1'b1;
      bus.addr  = a;
      bus.wen   = we;
      bus.wdata = d;
      acked = 1'b0;
      rdv   = 32'b0;
      lat   = 0;
      for (int i = 0; i < tmo; i++) begin
         @(negedge clk);
         lat++;
         if (bus.ready === 1'b1) begin
            acked = 1'b1;
            rdv   = bus.rdata;
            break;
         end
      end
      bus.valid = 1'b0;
      bus.wen   = 4'b0;
   endtask

   task automatic wr(input string tag, input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
      bit ak;
      logic [31:0] r;
      int l;
      bus_xfer(a, we, d, 10, ak, r, l);
      chk(tag, 32'(ak), 32'd1);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      bit ak;
      logic [31:0] r;
      int l;
      bus_xfer(a, 4'b0000, 32'b0, 10, ak, r, l);
      chk({tag, "_ack"}, 32'(ak), 32'd1);
      chk(tag, r, exp);
   endtask

   task automatic send(input logic [7:0] b, input logic [15:0] div, input bit keep);
      if (keep) sb.push_back({div, b});
      wr("tx_ack", BASE, 4'b0001, {24'h0, b});
   endtask

   task automatic wait_drain(input int tmo);
      bit done;
      done = 1'b0;
      for (int i = 0; i < tmo; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !mon_busy) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain", 32'(done), 32'd1);
   endtask

   // UART monitor: checks every cycle of each frame against the queued byte and bit period
   initial begin : uart_mon
      forever begin
         @(negedge clk);
         if (mon_en && tx === 1'b0) begin
            logic [23:0] ent;
            logic [7:0]  got;
            int          bad;
            int          div;
            logic        exp_bit;
            mon_busy = 1'b1;
            starts.push_back(cyc);
            if (sb.size() == 0) begin
               chk("frame_unexpected", 32'd1, 32'd0);
               ent = 24'h0;
            end else begin
               ent = sb.pop_front();
            end
            div = int'(ent[23:8]);
            bad = 0;
            got = 8'h00;
            for (int b = 0; b < 10; b++) begin
               for (int c = 0; c <= div; c++) begin
                  if (b != 0 || c != 0) @(negedge clk);
                  exp_bit = (b == 0) ? 1'b0 : ((b == 9) ? 1'b1 : ent[b-1]);
                  if (tx !== exp_bit) bad++;
                  if (b >= 1 && b <= 8 && c == div / 2) got[b-1] = tx;
               end
            end
            chk("frame_byte", 32'(got), 32'(ent[7:0]));
            chk("frame_shape", 32'(bad), 32'd0);
            mon_busy = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit ak;
      bit seen;
      logic [31:0] r;
      int l;
      int ack_cyc;
      int n0;

      bus.valid = 1'b0;
      bus.wen   = 4'b0;
      bus.addr  = 32'b0;
      bus.wdata = 32'b0;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_ready", 32'(bus.ready), 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      reset = 1'b0;
      rd_chk("rst_status", BASE + 32'h4, 32'h0000_0004);
      rd_chk("rst_div", BASE + 32'h8, 32'd15);

      // reset in the middle of a frame
      send(8'h12, 16'd15, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            seen = 1'b1;
            break;
         end
      end
      chk("pre_rst_start", 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1 chk("rst_async_tx", 32'(tx), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      rd_chk("post_rst_status", BASE + 32'h4, 32'h0000_0004);
      rd_chk("post_rst_div", BASE + 32'h8, 32'd15);
      mon_en = 1'b1;

      // single byte at DIV=3
      wr("div_ack", BASE + 32'h8, 4'b0011, 32'd3);
      sb.push_back({16'd3, 8'h55});
      n0 = starts.size();
      bus_xfer(BASE, 4'b0001, 32'h55, 10, ak, r, l);
      ack_cyc = cyc;
      chk("single_ack", 32'(ak), 32'd1);
      chk("single_lat", 32'(l), 32'd1);
      chk("tx_idle_at_ack", 32'(tx), 32'd1);
      rd_chk("busy_status", BASE + 32'h4, 32'h0000_0005);
      wait_drain(200);
      if (starts.size() > n0) chk("start_edge", 32'(starts[n0] - ack_cyc), 32'd1);
      else                    chk("start_seen", 32'd0, 32'd1);
      rd_chk("idle_status", BASE + 32'h4, 32'h0000_0004);

      // back-to-back frames
      n0 = starts.size();
      send(8'hA5, 16'd3, 1'b1);
      send(8'h3C, 16'd3, 1'b1);
      send(8'hFF, 16'd3, 1'b1);
      wait_drain(400);
      chk("b2b_frames", 32'(starts.size() - n0), 32'd3);
      if (starts.size() >= n0 + 3) begin
         chk("b2b_gap1", 32'(starts[n0+1] - starts[n0]), 32'd40);
         chk("b2b_gap2", 32'(starts[n0+2] - starts[n0+1]), 32'd40);
      end

      // overflow: 10 writes into a depth-8 FIFO
      wr("div_ack", BASE + 32'h8, 4'b0011, 32'd15);
      for (int i = 0; i < 10; i++) send(8'(8'h30 + i), 16'd15, i < 9);
      rd_chk("ovf_status", BASE + 32'h4, 32'h0000_080B);
      rd_chk("ovf_cleared", BASE + 32'h4, 32'h0000_0803);
      wait_drain(2000);
      rd_chk("ovf_idle", BASE + 32'h4, 32'h0000_0004);

      // DIV change during a frame affects only the next frame
      wr("div_ack", BASE + 32'h8, 4'b0011, 32'd7);
      send(8'h81, 16'd7, 1'b1);
      repeat (20) @(negedge clk);
      wr("div_ack", BASE + 32'h8, 4'b0011, 32'd1);
      rd_chk("div_readback", BASE + 32'h8, 32'd1);
      send(8'h7E, 16'd1, 1'b1);
      wait_drain(300);

      // byte-lane writes to DIV
      wr("div_hi_ack", BASE + 32'h8, 4'b0010, 32'h0000_AB00);
      rd_chk("div_hi", BASE + 32'h8, 32'h0000_AB01);
      wr("div_ack", BASE + 32'h8, 4'b0011, 32'd0);

      // DIV=0: one cycle per bit
      send(8'hC3, 16'd0, 1'b1);
      wait_drain(100);

      // address decode
      n0 = starts.size();
      bus_xfer(BASE + 32'h10, 4'b0001, 32'h41, 8, ak, r, l);
      chk("miss_above", 32'(ak), 32'd0);
      bus_xfer(32'h0000_0000, 4'b0000, 32'h0, 8, ak, r, l);
      chk("miss_zero", 32'(ak), 32'd0);
      rd_chk("reg_c", BASE + 32'hC, 32'h0);
      @(negedge clk);
      chk("ready_drop", 32'(bus.ready), 32'd0);
      chk("rdata_drop", bus.rdata, 32'd0);
      rd_chk("txdata_rd", BASE, 32'h0);
      wr("reg_c_wr", BASE + 32'hC, 4'b1111, 32'hFFFF_FFFF);
      wr("status_wr", BASE + 32'h4, 4'b0001, 32'h42);
      repeat (30) @(negedge clk);
      chk("no_stray_frames", 32'(starts.size() - n0), 32'd0);
      rd_chk("final_status", BASE + 32'h4, 32'h0000_0004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
